// File: rtl/dvp_tx.sv
// dvp_tx: OV5640-style DVP transmitter sending RGB565 as two bytes per pixel with Vsync/Href framing.
// Defining DVP_TX_PATTERN_EN adds a pattern_en port and an internal 8-bar colour generator.
module dvp_tx #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720,
  parameter int VSYNC_LINES  = 4,
  parameter int V_BACK       = 16,
  parameter int V_FRONT      = 4,
  parameter int H_BLANK      = 256
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
`ifdef DVP_TX_PATTERN_EN
  input  logic        pattern_en,
`endif
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic        frame_done,
  output logic        underrun
);

  localparam int LINE_LEN  = 2 * IMAGE_WIDTH + H_BLANK;
  localparam int ACT_BYTES = 2 * IMAGE_WIDTH;
  localparam int HW        = $clog2(LINE_LEN);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int V_MAX = max2(max2(VSYNC_LINES, V_BACK), max2(IMAGE_HEIGHT, V_FRONT));
  localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;
  logic [VW-1:0]   v_last;
  logic            line_end;
  logic            period_end;
  logic            vsync_entry;
  logic            pixel_slot;
  logic            pat_mode;
  logic [15:0]     bar_pixel;
  logic [15:0]     pix_reg;
  logic            vsync_next;
  logic            href_next;
  logic [7:0]      data_next;
  logic            frame_done_next;

  // Last line index of the current vertical region.
  always_comb begin
    v_last = '0;
    case (state_reg)
      S_VSYNC:  v_last = VW'(VSYNC_LINES - 1);
      S_VBACK:  v_last = VW'(V_BACK - 1);
      S_ACTIVE: v_last = VW'(IMAGE_HEIGHT - 1);
      S_VFRONT: v_last = VW'(V_FRONT - 1);
      default:  v_last = '0;
    endcase
  end

  assign line_end   = (h_cnt_reg == HW'(LINE_LEN - 1));
  assign period_end = line_end && (v_cnt_reg == v_last);

  // Next-state and counter logic.
  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (state_reg == S_IDLE) begin
      h_cnt_next = '0;
      v_cnt_next = '0;
      if (Enable) begin
        state_next = S_VSYNC;
      end
    end else if (line_end) begin
      h_cnt_next = '0;
      if (period_end) begin
        v_cnt_next = '0;
        case (state_reg)
          S_VSYNC:  state_next = S_VBACK;
          S_VBACK:  state_next = S_ACTIVE;
          S_ACTIVE: state_next = S_VFRONT;
          S_VFRONT: state_next = Enable ? S_VSYNC : S_IDLE;
          default:  state_next = S_IDLE;
        endcase
      end else begin
        v_cnt_next = v_cnt_reg + VW'(1);
      end
    end else begin
      h_cnt_next = h_cnt_reg + HW'(1);
    end
  end

  assign vsync_entry = (state_next == S_VSYNC) && (state_reg != S_VSYNC);

  // A pixel is fetched in the cycle whose successor is a high-byte slot.
  assign pixel_slot = (state_next == S_ACTIVE) && !h_cnt_next[0] &&
                      (h_cnt_next < HW'(ACT_BYTES));

`ifdef DVP_TX_PATTERN_EN
  localparam int BAR_W = IMAGE_WIDTH / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [127:0] BAR_COLOURS = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  logic [15:0]   bar_rom [8];
  logic          pat_mode_reg;
  logic [2:0]    bar_idx_reg;
  logic [BW-1:0] bar_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bar
      assign bar_rom[gi] = BAR_COLOURS[gi*16 +: 16];
    end
  endgenerate

  // Bar position advances per fetched pixel and rewinds outside the active bytes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pat_mode_reg <= 1'b0;
      bar_idx_reg  <= '0;
      bar_cnt_reg  <= '0;
    end else begin
      if (vsync_entry) begin
        pat_mode_reg <= pattern_en;
      end
      if (pixel_slot) begin
        if (bar_cnt_reg == BW'(BAR_W - 1)) begin
          bar_cnt_reg <= '0;
          bar_idx_reg <= bar_idx_reg + 3'd1;
        end else begin
          bar_cnt_reg <= bar_cnt_reg + BW'(1);
        end
      end else if (state_reg != S_ACTIVE || h_cnt_reg >= HW'(ACT_BYTES)) begin
        bar_cnt_reg <= '0;
        bar_idx_reg <= '0;
      end
    end
  end

  assign pat_mode  = pat_mode_reg;
  assign bar_pixel = bar_rom[bar_idx_reg];
`else
  assign pat_mode  = 1'b0;
  assign bar_pixel = '0;
`endif

  // Output decode from the current timing position.
  always_comb begin
    pixel_ready     = pixel_slot && !pat_mode;
    vsync_next      = (state_reg == S_VSYNC);
    href_next       = (state_reg == S_ACTIVE) && (h_cnt_reg < HW'(ACT_BYTES));
    frame_done_next = (state_reg == S_VFRONT) && period_end;
    data_next       = 8'h00;
    if (href_next) begin
      data_next = h_cnt_reg[0] ? pix_reg[7:0] : pix_reg[15:8];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= S_IDLE;
      h_cnt_reg  <= '0;
      v_cnt_reg  <= '0;
      pix_reg    <= '0;
      Vsync      <= 1'b0;
      Href       <= 1'b0;
      Data       <= 8'h00;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      h_cnt_reg  <= h_cnt_next;
      v_cnt_reg  <= v_cnt_next;
      Vsync      <= vsync_next;
      Href       <= href_next;
      Data       <= data_next;
      frame_done <= frame_done_next;
      if (vsync_entry) begin
        underrun <= 1'b0;
      end
      // A missing pixel is sent as black; timing never stalls.
      if (pixel_slot) begin
        if (pat_mode) begin
          pix_reg <= bar_pixel;
        end else if (pixel_valid) begin
          pix_reg <= pixel_data;
        end else begin
          pix_reg  <= 16'h0000;
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_tx.sv
// Scoreboard bench for dvp_tx: stimulus pushes expected bytes, a monitor pops them while Href is high.
`timescale 1ns/1ps
module tb_dvp_tx;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Enable = 1'b0;
  logic [15:0] pixel_data = 16'h0000;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        Vsync;
  logic        Href;
  logic [7:0]  Data;
  logic        frame_done;
  logic        underrun;
`ifdef DVP_TX_PATTERN_EN
  logic        pattern_en = 1'b0;
`endif

  always #5 Clk = ~Clk;

  dvp_tx #(
    .IMAGE_WIDTH (8),
    .IMAGE_HEIGHT(2),
    .VSYNC_LINES (1),
    .V_BACK      (1),
    .V_FRONT     (1),
    .H_BLANK     (4)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Enable     (Enable),
`ifdef DVP_TX_PATTERN_EN
    .pattern_en (pattern_en),
`endif
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .Vsync      (Vsync),
    .Href       (Href),
    .Data       (Data),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];
  int         vs_rise_q[$];
  int         vs_fall_q[$];
  int         hr_q[$];
  int         fd_q[$];
  int         pix_num = 0;
  int         ready_cnt = 0;
  bit         drop_en = 1'b0;
  bit         pat_test = 1'b0;
  bit         rst_q = 1'b1;
  bit         href_prev = 1'b0;
  bit         vs_prev = 1'b0;
  bit         fd_prev = 1'b0;
  bit         need_hr = 1'b0;
  int         run_len = 0;
  int         frame_bytes = 0;
  int         n0;
  int         m;

  function automatic int now_c();
    return int'($time / 10);
  endfunction

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock step; inputs change 1ns after the falling edge.
  task automatic cyc();
    @(negedge Clk);
    #1;
    if (pixel_ready) begin
      ready_cnt++;
      if (!pat_test) begin
        if (drop_en && pix_num == 2) begin
          pixel_valid = 1'b0;
          pixel_data  = 16'h1234;
          sb_q.push_back(8'h00);
          sb_q.push_back(8'h00);
        end else begin
          pixel_valid = 1'b1;
          pixel_data  = {8'h00, 8'(pix_num + 1)};
          sb_q.push_back(8'h00);
          sb_q.push_back(8'(pix_num + 1));
        end
        pix_num = (pix_num + 1) % 16;
      end
    end else begin
      pixel_valid = !pat_test;
      pixel_data  = 16'hBEEF;
    end
  endtask

  task automatic clear_q();
    vs_rise_q.delete();
    vs_fall_q.delete();
    hr_q.delete();
    fd_q.delete();
    ready_cnt = 0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    for (int i = 0; i < budget && fd_q.size() < target; i++) cyc();
    chk("wait_frame_done", int'(fd_q.size() >= target), 1);
  endtask

  task automatic pulse();
    n0 = now_c();
    Enable = 1'b1;
    cyc();
    Enable = 1'b0;
  endtask

  task automatic idle_check(input string name);
    chk(name, int'({Vsync, Href, Data, pixel_ready, frame_done}), 0);
  endtask

  initial forever begin
    @(posedge Clk);
    rst_q = Rst;
  end

  // Monitor: pops the scoreboard on every Href byte and records framing events.
  initial forever begin
    @(negedge Clk);
    if (rst_q) begin
      sb_q.delete();
      run_len = 0;
      frame_bytes = 0;
    end else begin
      if (Href) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got byte 0x%0h, expected no byte", Data);
        end else begin
          chk("data_byte", int'(Data), int'(sb_q.pop_front()));
        end
        run_len++;
        frame_bytes++;
      end else begin
        chk("blank_data", int'(Data), 0);
        if (href_prev) chk("href_run", run_len, 16);
        run_len = 0;
      end
      if (Vsync && !vs_prev) vs_rise_q.push_back(now_c());
      if (!Vsync && vs_prev) begin
        vs_fall_q.push_back(now_c());
        need_hr = 1'b1;
      end
      if (Href && !href_prev && need_hr) begin
        hr_q.push_back(now_c());
        need_hr = 1'b0;
      end
      if (frame_done) begin
        fd_q.push_back(now_c());
        chk("fd_single_pulse", int'(fd_prev), 0);
        chk("frame_bytes", frame_bytes, 32);
        $display("frame_done at cycle %0d, %0d bytes, underrun=%0d", now_c(), frame_bytes, underrun);
        frame_bytes = 0;
      end
    end
    href_prev = Href;
    vs_prev   = Vsync;
    fd_prev   = frame_done;
  end

  initial begin
    repeat (3) cyc();
    chk("reset_outputs", int'({Vsync, Href, Data, pixel_ready, frame_done, underrun}), 0);
    Rst = 1'b0;
    cyc();

    // A: continuous Enable, two back-to-back frames, Enable dropped mid second frame.
    clear_q();
    n0 = now_c();
    Enable = 1'b1;
    wait_fd(1, 200);
    repeat (50) cyc();
    Enable = 1'b0;
    wait_fd(2, 200);
    repeat (30) cyc();
    chk("A_vs_latency", at(vs_rise_q, 0) - n0, 2);
    chk("A_vs_width", at(vs_fall_q, 0) - at(vs_rise_q, 0), 20);
    chk("A_vback", at(hr_q, 0) - at(vs_fall_q, 0), 20);
    chk("A_fd_offset", at(fd_q, 0) - at(vs_rise_q, 0), 99);
    chk("A_fd_period", at(fd_q, 1) - at(fd_q, 0), 100);
    chk("A_b2b_vsync", at(vs_rise_q, 1) - at(fd_q, 0), 1);
    chk("A_frames", vs_rise_q.size(), 2);
    chk("A_ready_cnt", ready_cnt, 32);
    chk("A_underrun", int'(underrun), 0);
    idle_check("A_idle_outputs");
    chk("A_sb_empty", sb_q.size(), 0);
    $display("scenario A: back-to-back stream frames");

    // C: pixel 3 of line 0 missing.
    clear_q();
    drop_en = 1'b1;
    pulse();
    wait_fd(1, 150);
    repeat (10) cyc();
    drop_en = 1'b0;
    chk("C_underrun_set", int'(underrun), 1);
    chk("C_ready_cnt", ready_cnt, 16);
    chk("C_sb_empty", sb_q.size(), 0);
    $display("scenario C: underrun frame");

    // B: single-cycle Enable pulse runs exactly one frame.
    clear_q();
    pulse();
    for (int i = 0; i < 5 && vs_rise_q.size() == 0; i++) cyc();
    chk("B_underrun_cleared", int'(underrun), 0);
    wait_fd(1, 150);
    repeat (30) cyc();
    chk("B_vs_latency", at(vs_rise_q, 0) - n0, 2);
    chk("B_vs_width", at(vs_fall_q, 0) - at(vs_rise_q, 0), 20);
    chk("B_vback", at(hr_q, 0) - at(vs_fall_q, 0), 20);
    chk("B_fd_offset", at(fd_q, 0) - at(vs_rise_q, 0), 99);
    chk("B_frames", vs_rise_q.size(), 1);
    chk("B_fd_count", fd_q.size(), 1);
    chk("B_ready_cnt", ready_cnt, 16);
    chk("B_underrun", int'(underrun), 0);
    idle_check("B_idle_outputs");
    $display("scenario B: single pulse frame");

    // D: reset in the middle of the first active line (h_cnt=7).
    clear_q();
    Enable = 1'b1;
    for (int i = 0; i < 60 && hr_q.size() == 0; i++) cyc();
    chk("D_wait_href", hr_q.size(), 1);
    repeat (6) cyc();
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    m = now_c();
    chk("D_reset_outputs", int'({Vsync, Href, Data, pixel_ready, frame_done, underrun}), 0);
    pix_num = 0;
    clear_q();
    for (int i = 0; i < 5 && vs_rise_q.size() == 0; i++) cyc();
    chk("D_restart_latency", at(vs_rise_q, 0) - m, 2);
    Enable = 1'b0;
    wait_fd(1, 150);
    repeat (10) cyc();
    chk("D_ready_cnt", ready_cnt, 16);
    chk("D_sb_empty", sb_q.size(), 0);
    $display("scenario D: mid-line reset and restart");

    // E: Enable dropped during VBACK; the frame still completes.
    clear_q();
    Enable = 1'b1;
    for (int i = 0; i < 30 && vs_fall_q.size() == 0; i++) cyc();
    repeat (5) cyc();
    Enable = 1'b0;
    wait_fd(1, 150);
    repeat (40) cyc();
    chk("E_fd_count", fd_q.size(), 1);
    chk("E_frames", vs_rise_q.size(), 1);
    chk("E_ready_cnt", ready_cnt, 16);
    idle_check("E_idle_outputs");
    $display("scenario E: Enable dropped in VBACK");

`ifdef DVP_TX_PATTERN_EN
    begin
      logic [7:0] pat_bytes [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                     8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
      clear_q();
      pat_test = 1'b1;
      pattern_en = 1'b1;
      for (int l = 0; l < 2; l++)
        for (int b = 0; b < 16; b++) sb_q.push_back(pat_bytes[b]);
      pulse();
      repeat (3) cyc();
      pattern_en = 1'b0;
      wait_fd(1, 150);
      repeat (10) cyc();
      chk("F_ready_cnt", ready_cnt, 0);
      chk("F_underrun", int'(underrun), 0);
      chk("F_sb_empty", sb_q.size(), 0);
      pat_test = 1'b0;
      $display("scenario F: colour bars");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
